// File: rtl/vnorm_sqrt.sv
`default_nettype none
// ============================================================================
// Module   : vnorm_sqrt
// Purpose  : Multicycle integer square root (one root bit per clock) giving
//            floor(sqrt(radicand)) and remainder, with a one-cycle done pulse.
// Revision : 1.0  initial release
// ============================================================================
module vnorm_sqrt #(
  parameter int word_size = 24
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [word_size-1:0]   radicand,
  output logic [word_size/2-1:0] root,
  output logic [word_size/2:0]   remainder,
  output logic                   busy,
  output logic                   done
);

  localparam int RW  = word_size / 2;
  localparam int RBW = RW + 2;
  localparam int CW  = (RW > 1) ? $clog2(RW) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [word_size-1:0] r_x;
  logic [RW-1:0]        r_q;
  logic [RBW-1:0]       r_r;
  logic [CW-1:0]        r_cnt;
  logic [RW-1:0]        r_root;
  logic [RW:0]          r_rem;
  logic                 r_busy;
  logic                 r_done;

  logic                 w_accept;
  logic                 w_last;
  logic [RBW-1:0]       w_rx;
  logic [RBW-1:0]       w_t;
  logic [RW-1:0]        w_q_nxt;
  logic [RBW-1:0]       w_r_nxt;

  assign w_accept = start && ((r_state == S_IDLE) || (r_state == S_FIN));
  assign w_last   = (r_state == S_CALC) && (r_cnt == CW'(RW - 1));

  // Trial subtraction; the RBW-bit wrap is safe because the true difference
  // always lies within the signed RBW-bit range.
  assign w_rx    = {r_r[RBW-3:0], r_x[word_size-1 -: 2]};
  assign w_t     = w_rx - {r_q, 2'b01};
  assign w_q_nxt = {r_q[RW-2:0], ~w_t[RBW-1]};
  assign w_r_nxt = w_t[RBW-1] ? w_rx : w_t;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_CALC;
      S_CALC:  if (w_last) w_state_nxt = S_FIN;
      S_FIN:   w_state_nxt = start ? S_CALC : S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_x    <= '0;
      r_q    <= '0;
      r_r    <= '0;
      r_cnt  <= '0;
      r_root <= '0;
      r_rem  <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_busy <= (w_state_nxt == S_CALC);
      r_done <= (w_state_nxt == S_FIN);
      if (w_accept) begin
        r_x   <= radicand;
        r_q   <= '0;
        r_r   <= '0;
        r_cnt <= '0;
      end else if (r_state == S_CALC) begin
        r_x   <= r_x << 2;
        r_q   <= w_q_nxt;
        r_r   <= w_r_nxt;
        r_cnt <= r_cnt + CW'(1);
      end
      // Outputs only ever see the completed result of the final iteration.
      if (w_last) begin
        r_root <= w_q_nxt;
        r_rem  <= w_r_nxt[RW:0];
      end
    end
  end

  assign root      = r_root;
  assign remainder = r_rem;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_vnorm_sqrt.sv
`default_nettype none
// ============================================================================
// Module   : tb_vnorm_sqrt
// Purpose  : Scoreboard bench for vnorm_sqrt: directed vectors plus a sweep.
// Revision : 1.0  initial release
// ============================================================================
module tb_vnorm_sqrt;

  localparam int WS = 24;
  localparam int LAT = WS / 2;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            start = 1'b0;
  logic [WS-1:0]   radicand = '0;
  logic [WS/2-1:0] root;
  logic [WS/2:0]   remainder;
  logic            busy;
  logic            done;

  typedef struct {
    int    root;
    int    rem;
    longint cyc;
  } exp_t;

  exp_t   sb[$];
  int     n_checks = 0;
  int     n_pass = 0;
  longint cyc = 0;
  int     busy_cnt = 0;
  int     overlap_cnt = 0;
  int     done_cnt = 0;

  vnorm_sqrt #(.word_size(WS)) dut (
    .clk(clk), .rst(rst), .start(start), .radicand(radicand),
    .root(root), .remainder(remainder), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor: every done pulse must match the oldest expected result.
  always @(negedge clk) begin
    if (busy) busy_cnt++;
    if (busy && done) overlap_cnt++;
    if (!rst && done) begin
      done_cnt++;
      if (sb.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("root", root, e.root);
        chk("remainder", remainder, e.rem);
        chk("done_cycle", cyc, e.cyc);
      end
    end
  end

  function automatic longint isqrt(input longint x);
    longint r;
    r = longint'($sqrt(real'(x)));
    while (r * r > x) r--;
    while ((r + 1) * (r + 1) <= x) r++;
    return r;
  endfunction

  // Called at a negedge; start is sampled on the following posedge.
  task automatic do_start(input longint rad, input int er, input int erem, input bit push);
    exp_t e;
    start = 1'b1;
    radicand = WS'(rad);
    if (push) begin
      e.root = er;
      e.rem  = erem;
      e.cyc  = cyc + 1 + LAT;
      sb.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
    radicand = '0;
  endtask

  task automatic wait_done(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 4 * LAT && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    if (!seen) chk({name, "_timeout"}, 0, 1);
  endtask

  int b0;
  longint r, m;

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_root", root, 0);
    chk("reset_rem", remainder, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);

    b0 = busy_cnt;
    do_start(0, 0, 0, 1);
    wait_done("zero");
    chk("busy_len", busy_cnt - b0, LAT);

    @(negedge clk);
    do_start(144, 12, 0, 1);
    wait_done("r144");
    @(negedge clk);
    do_start(145, 12, 1, 1);
    wait_done("r145");
    @(negedge clk);
    do_start(16777215, 4095, 8190, 1);
    wait_done("rmax");

    // Start during CALC must be ignored.
    repeat (2) @(negedge clk);
    b0 = done_cnt;
    do_start(1000000, 1000, 0, 1);
    repeat (4) @(negedge clk);
    start = 1'b1;
    radicand = 24'd4;
    @(negedge clk);
    start = 1'b0;
    wait_done("ignored");
    repeat (LAT + 4) @(negedge clk);
    chk("single_done", done_cnt - b0, 1);

    // Back-to-back: second start issued in the FIN cycle.
    do_start(99, 9, 18, 1);
    wait_done("b2b_first");
    do_start(50, 7, 1, 1);
    wait_done("b2b_second");

    // Reset mid-CALC discards the operation.
    @(negedge clk);
    do_start(12345, 0, 0, 0);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_root", root, 0);
    chk("rst_rem", remainder, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    @(negedge clk);
    chk("rst_idle_busy", busy, 0);
    do_start(81, 9, 0, 1);
    wait_done("r81");

    for (int i = 0; i < 1000; i++) begin
      m = longint'($urandom & 32'h00FF_FFFF);
      r = isqrt(m);
      do_start(m, int'(r), int'(m - r * r), 1);
      wait_done("sweep");
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    chk("busy_done_overlap", overlap_cnt, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
